uart_receiver: RTL and testbench

Serial-to-parallel UART receiver, the receive end of the team's 8N1, one-bit-per-clock UART link clocked by clock_10KHz. It samples the line once per clock and checks the stop bit. Each good byte is stored in an internal buffer indexed 1..NUM_BYTES, matching the transmitter's message ROM, so a loopback bench can read back and compare the whole message. After NUM_BYTES good bytes it raises Done and ignores the line until reset.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_receiver_if.sv | 31 +++
 rtl/uart_rx_sync.sv | 42 ++++
 rtl/uart_receiver.sv | 140 ++++++++++++++
 tb/tb_uart_receiver.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART transmitter and receiver:
//   uart_state_e      - receiver state encoding
//   DATA_BITS         - payload bits per frame (8N1)
//   BIT_CNT_W         - width of the in-frame bit counter
//   COUNT_W           - width of the received-byte counter / buffer address
//   DEFAULT_NUM_BYTES - message length shared with the transmitter ROM
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS         = 8;
    localparam int BIT_CNT_W         = $clog2(DATA_BITS);
    localparam int COUNT_W           = 6;
    localparam int DEFAULT_NUM_BYTES = 38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STOP,
        ST_BREAK,
        ST_FINISH
    } uart_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
// Parallel-side bundle of the UART receiver.
//   RX_data/RX_valid  - last good byte and its one-cycle strobe
//   Framing_error     - sticky stop-bit error flag
//   Byte_count/Done   - progress through the message
//   Rd_addr/Rd_data   - combinational read port into the receive buffer
// master: the receiver; slave: whoever consumes the message.
// ---------------------------------------------------------------------------
interface uart_receiver_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] RX_data;
    logic                 RX_valid;
    logic                 Framing_error;
    logic [COUNT_W-1:0]   Byte_count;
    logic                 Done;
    logic [COUNT_W-1:0]   Rd_addr;
    logic [DATA_BITS-1:0] Rd_data;

    modport master (
        output RX_data, RX_valid, Framing_error, Byte_count, Done, Rd_data,
        input  Rd_addr
    );

    modport slave (
        input  RX_data, RX_valid, Framing_error, Byte_count, Done, Rd_data,
        output Rd_addr
    );

endinterface

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// SYNC_STAGES-deep synchronizer for the asynchronous serial line. Flops reset
// to 1 so the line looks idle out of reset. SYNC_STAGES=0 is a plain wire,
// used when the transmitter shares the receiver's clock.
//   clock_10KHz, Reset_n - clock and async active-low reset
//   din                  - raw serial line
//   dout                 - synchronized serial line
// ---------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_10KHz,
    input  logic Reset_n,
    input  logic din,
    output logic dout
);

    generate
        if (SYNC_STAGES == 0) begin : g_wire
            assign dout = din;
        end else begin : g_flops
            logic [SYNC_STAGES-1:0] chain;

            // NOTE: flops are written with <= so every stage samples the
            // previous stage's old value; blocking would collapse the chain.
            always_ff @(posedge clock_10KHz or negedge Reset_n) begin
                if (!Reset_n) begin
                    chain <= '1;
                end else begin
                    chain[0] <= din;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign dout = chain[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8N1 receiver, one bit per clock. Samples the synchronized line once per
// cycle, checks the stop bit, and stores each good byte at buffer address
// Byte_count+1 (addresses 1..NUM_BYTES, matching the transmitter ROM). After
// NUM_BYTES good bytes it raises Done and ignores the line until reset.
//   clock_10KHz, Reset_n - clock and async active-low reset
//   RXD                  - serial line, idle high, LSB first
//   rx_bus (master)      - RX_data/RX_valid, Framing_error, Byte_count,
//                          Done, and the Rd_addr/Rd_data buffer read port
// ---------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int NUM_BYTES   = DEFAULT_NUM_BYTES,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clock_10KHz,
    input  logic            Reset_n,
    input  logic            RXD,
    uart_receiver_if.master rx_bus
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [COUNT_W-1:0]   LAST_ADDR = COUNT_W'(NUM_BYTES);

    logic s;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock_10KHz (clock_10KHz),
        .Reset_n     (Reset_n),
        .din         (RXD),
        .dout        (s)
    );

    uart_state_e          state,      state_next;
    logic [BIT_CNT_W-1:0] bit_cnt,    bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic [DATA_BITS-1:0] rx_data_q,  rx_data_next;
    logic                 rx_valid_q, rx_valid_next;
    logic                 fe_q,       fe_next;
    logic [COUNT_W-1:0]   count_q,    count_next;
    logic                 wr_en;
    logic [COUNT_W-1:0]   wr_addr;

    logic [DATA_BITS-1:0] buffer [1:NUM_BYTES];

    always_ff @(posedge clock_10KHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            fe_q       <= 1'b0;
            count_q    <= '0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            rx_data_q  <= rx_data_next;
            rx_valid_q <= rx_valid_next;
            fe_q       <= fe_next;
            count_q    <= count_next;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift_reg;
        rx_data_next  = rx_data_q;
        rx_valid_next = 1'b0;
        fe_next       = fe_q;
        count_next    = count_q;
        wr_en         = 1'b0;

        case (state)
            ST_IDLE: begin
                // This low sample is the start bit itself.
                if (!s) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                shift_next[bit_cnt] = s;
                bit_cnt_next        = bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (s) begin
                    rx_data_next  = shift_reg;
                    rx_valid_next = 1'b1;
                    wr_en         = 1'b1;
                    count_next    = count_q + 1'b1;
                    state_next    = (count_next == LAST_ADDR) ? ST_FINISH : ST_IDLE;
                end else begin
                    fe_next    = 1'b1;
                    state_next = ST_BREAK;
                end
            end
            ST_BREAK: begin
                // A held-low line is a break, not a stream of start bits.
                if (s) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FINISH: begin
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_addr = count_q + 1'b1;

    // NOTE: the message buffer has no reset; it maps to distributed RAM and
    // unwritten entries are never meaningful to a reader.
    always_ff @(posedge clock_10KHz) begin
        if (wr_en) begin
            buffer[wr_addr] <= shift_reg;
        end
    end

    assign rx_bus.Rd_data = (rx_bus.Rd_addr != '0 && rx_bus.Rd_addr <= LAST_ADDR)
                          ? buffer[rx_bus.Rd_addr] : '0;

    assign rx_bus.RX_data       = rx_data_q;
    assign rx_bus.RX_valid      = rx_valid_q;
    assign rx_bus.Framing_error = fe_q;
    assign rx_bus.Byte_count    = count_q;
    assign rx_bus.Done          = (state == ST_FINISH);

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Two receivers: dut2 (SYNC_STAGES=2) carries most scenarios, dut0
// (SYNC_STAGES=0) the same-clock back-to-back case. Expected bytes come from
// a frame-level model: a queue of accepted bytes plus a sticky error flag.
// ---------------------------------------------------------------------------
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int NB = DEFAULT_NUM_BYTES;

    logic clock_10KHz = 1'b0;
    logic Reset_n;
    logic rxd2, rxd0;

    uart_receiver_if bus2();
    uart_receiver_if bus0();

    uart_receiver #(.NUM_BYTES(NB), .SYNC_STAGES(2)) dut2 (
        .clock_10KHz (clock_10KHz),
        .Reset_n     (Reset_n),
        .RXD         (rxd2),
        .rx_bus      (bus2)
    );

    uart_receiver #(.NUM_BYTES(NB), .SYNC_STAGES(0)) dut0 (
        .clock_10KHz (clock_10KHz),
        .Reset_n     (Reset_n),
        .RXD         (rxd0),
        .rx_bus      (bus0)
    );

    always #5 clock_10KHz = ~clock_10KHz;

    int edge_cnt = 0;
    always @(posedge clock_10KHz) edge_cnt++;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitors, sampled on the falling edge.
    int         p2_edge[$];
    logic [7:0] p2_data[$];
    logic       p2_done[$];
    int         p0_edge[$];

    always @(negedge clock_10KHz) begin
        if (bus2.RX_valid === 1'b1) begin
            p2_edge.push_back(edge_cnt);
            p2_data.push_back(bus2.RX_data);
            p2_done.push_back(bus2.Done);
        end
        if (bus0.RX_valid === 1'b1) begin
            p0_edge.push_back(edge_cnt);
        end
    end

    // Frame-level reference model for dut2.
    logic [7:0] m_buf[$];
    logic       m_fe;

    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (m_buf.size() < NB) begin
            if (stop) m_buf.push_back(d);
            else      m_fe = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock_10KHz);
        #1;
    endtask

    task automatic send(input bit to_dut0, input logic [7:0] d, input logic stop);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (to_dut0) rxd0 = frame[i];
            else         rxd2 = frame[i];
            tick();
        end
        if (!to_dut0) model_frame(d, stop);
    endtask

    task automatic do_reset();
        rxd2 = 1'b1;
        rxd0 = 1'b1;
        Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        tick();
        p2_edge.delete(); p2_data.delete(); p2_done.delete(); p0_edge.delete();
        m_buf.delete();
        m_fe = 1'b0;
    endtask

    initial begin
        int         se;
        logic [7:0] d;
        logic [7:0] msg[NB];

        bus2.Rd_addr = '0;
        bus0.Rd_addr = '0;

        // Idle line after reset.
        do_reset();
        tick(30);
        check("idle_pulses",   p2_edge.size(), 0);
        check("idle_rx_data",  bus2.RX_data, 0);
        check("idle_fe",       bus2.Framing_error, 0);
        check("idle_count",    bus2.Byte_count, 0);
        check("idle_done",     bus2.Done, 0);
        check("idle_rd0",      bus2.Rd_data, 0);
        check("idle_dut0",     p0_edge.size(), 0);

        // Single 0x41 frame through the 2-stage synchronizer.
        se = edge_cnt + 1;
        send(1'b0, 8'h41, 1'b1);
        rxd2 = 1'b1;
        tick(4);
        check("one_pulses",    p2_edge.size(), 1);
        check("one_edge",      p2_edge[0], se + 11);
        check("one_data",      p2_data[0], m_buf[0]);
        check("one_count",     bus2.Byte_count, m_buf.size());
        bus2.Rd_addr = 6'd1;
        #1 check("one_rd1",    bus2.Rd_data, m_buf[0]);

        // Full message, back-to-back, then one extra frame.
        do_reset();
        for (int i = 0; i < NB; i++) msg[i] = 8'($urandom);
        se = edge_cnt + 1;
        for (int i = 0; i < NB; i++) send(1'b0, msg[i], 1'b1);
        rxd2 = 1'b1;
        tick(4);
        check("msg_pulses",    p2_edge.size(), NB);
        check("msg_last_edge", p2_edge[NB-1], se + 11 + 10 * (NB - 1));
        check("msg_count",     bus2.Byte_count, NB);
        check("msg_done",      bus2.Done, 1);
        check("msg_done_last", p2_done[NB-1], 1);
        check("msg_done_prev", p2_done[NB-2], 0);
        for (int i = 0; i < NB; i++) begin
            check("msg_model",  m_buf[i], msg[i]);
            check("msg_pulse",  p2_data[i], m_buf[i]);
            bus2.Rd_addr = 6'(i + 1);
            #1 check("msg_rd",  bus2.Rd_data, m_buf[i]);
        end
        bus2.Rd_addr = 6'(NB + 1);
        #1 check("msg_rd_oob", bus2.Rd_data, 0);
        d = 8'($urandom);
        send(1'b0, d, 1'b1);
        rxd2 = 1'b1;
        tick(4);
        check("extra_pulses",  p2_edge.size(), NB);
        check("extra_count",   bus2.Byte_count, m_buf.size());
        check("extra_done",    bus2.Done, 1);

        // Bad stop bit, break, then recovery.
        do_reset();
        send(1'b0, 8'h55, 1'b0);
        rxd2 = 1'b0;
        tick(5);
        rxd2 = 1'b1;
        tick(2);
        check("fe_pulses",     p2_edge.size(), 0);
        check("fe_flag",       bus2.Framing_error, m_fe);
        check("fe_count",      bus2.Byte_count, 0);
        send(1'b0, 8'h33, 1'b1);
        rxd2 = 1'b1;
        tick(4);
        check("fe_rec_pulses", p2_edge.size(), 1);
        check("fe_rec_count",  bus2.Byte_count, m_buf.size());
        bus2.Rd_addr = 6'd1;
        #1 check("fe_rec_rd1", bus2.Rd_data, m_buf[0]);
        check("fe_sticky",     bus2.Framing_error, m_fe);

        // Reset during D3 of 0xA5, then a clean 0x3C frame.
        do_reset();
        d = 8'hA5;
        rxd2 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            rxd2 = d[i];
            tick();
        end
        rxd2 = d[3];
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        rxd2 = 1'b1;
        tick(3);
        check("mid_no_pulse",  p2_edge.size(), 0);
        check("mid_count0",    bus2.Byte_count, 0);
        send(1'b0, 8'h3C, 1'b1);
        rxd2 = 1'b1;
        tick(4);
        check("mid_pulses",    p2_edge.size(), 1);
        check("mid_rx_data",   bus2.RX_data, m_buf[0]);
        check("mid_count",     bus2.Byte_count, 1);
        bus2.Rd_addr = 6'd1;
        #1 check("mid_rd1",    bus2.Rd_data, 8'h3C);

        // Zero-stage synchronizer, two frames with no gap.
        do_reset();
        se = edge_cnt + 1;
        send(1'b1, 8'hFF, 1'b1);
        send(1'b1, 8'h00, 1'b1);
        rxd0 = 1'b1;
        tick(4);
        check("s0_pulses",     p0_edge.size(), 2);
        check("s0_edge0",      p0_edge[0], se + 9);
        check("s0_edge1",      p0_edge[1], se + 19);
        check("s0_rx_data",    bus0.RX_data, 8'h00);
        check("s0_count",      bus0.Byte_count, 2);
        bus0.Rd_addr = 6'd1;
        #1 check("s0_rd1",     bus0.Rd_data, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
